// File: rtl/fuzz_top_pkg.sv
// Shared field map and constants for the fuzz_top mixing datapath.
// Every y field position is defined here so the packer and stats agree.
package fuzz_top_pkg;

    localparam int IN_W = 52;
    localparam int Y_W  = 127;

    localparam logic [7:0] MAX_RST = 8'h80;

    localparam int W0_LSB   = 0;
    localparam int W0_MSB   = 7;
    localparam int W1_LSB   = 8;
    localparam int W1_MSB   = 11;
    localparam int W2_LSB   = 12;
    localparam int W2_MSB   = 32;
    localparam int W3_LSB   = 33;
    localparam int W3_MSB   = 51;
    localparam int SUM_LSB  = 52;
    localparam int SUM_MSB  = 60;
    localparam int PROD_LSB = 61;
    localparam int PROD_MSB = 72;
    localparam int MIX_LSB  = 73;
    localparam int MIX_MSB  = 93;
    localparam int PAR_LSB  = 94;
    localparam int PAR_MSB  = 94;
    localparam int ACC_LSB  = 95;
    localparam int ACC_MSB  = 110;
    localparam int CNT_LSB  = 111;
    localparam int CNT_MSB  = 118;
    localparam int MAX_LSB  = 119;
    localparam int MAX_MSB  = 126;

endpackage

// File: rtl/fuzz_top_stats.sv
// Running statistics: wrapping accumulator, sample counter and
// signed running maximum, all cleared by synchronous reset.
module fuzz_top_stats
    import fuzz_top_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] wire3_lo,
    input  logic [7:0]       wire0,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] cnt,
    output logic [7:0]       max
);

    logic [ACC_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [7:0]       max_d, max_q;

    always_comb begin
        acc_d = acc_q + wire3_lo;
        cnt_d = cnt_q + CNT_W'(1);
        max_d = max_q;
        // strict compare: a tie keeps the held value
        if ($signed(wire0) > $signed(max_q)) begin
            max_d = wire0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            max_q <= MAX_RST;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            max_q <= max_d;
        end
    end

    assign acc = acc_q;
    assign cnt = cnt_q;
    assign max = max_q;

endmodule

// File: rtl/fuzz_top_datapath.sv
// Registered mixing datapath: input copies, signed sum/product,
// xor mix, parity and running stats packed into one result word.
module fuzz_top_datapath
    import fuzz_top_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [18:0]    wire3,
    input  logic [20:0]    wire2,
    input  logic [3:0]     wire1,
    input  logic [7:0]     wire0,
    output logic [Y_W-1:0] y
);

    logic [7:0]  w0_d, w0_q;
    logic [3:0]  w1_d, w1_q;
    logic [20:0] w2_d, w2_q;
    logic [18:0] w3_d, w3_q;
    logic [8:0]  sum_d, sum_q;
    logic [11:0] prod_d, prod_q;
    logic [20:0] mix_d, mix_q;
    logic        par_d, par_q;

    logic signed [11:0] s0_x, s1_x;
    logic [IN_W-1:0]    in_all;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       max;

    always_comb begin
        w0_d   = wire0;
        w1_d   = wire1;
        w2_d   = wire2;
        w3_d   = wire3;
        sum_d  = {wire0[7], wire0} + {{5{wire1[3]}}, wire1};
        // 8x4 signed product never exceeds 12 bits
        s0_x   = $signed({{4{wire0[7]}}, wire0});
        s1_x   = $signed({{8{wire1[3]}}, wire1});
        prod_d = s0_x * s1_x;
        mix_d  = wire2 ^ {wire3, 2'b00};
        in_all = {wire3, wire2, wire1, wire0};
        par_d  = ^in_all;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q   <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
            w3_q   <= '0;
            sum_q  <= '0;
            prod_q <= '0;
            mix_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            w0_q   <= w0_d;
            w1_q   <= w1_d;
            w2_q   <= w2_d;
            w3_q   <= w3_d;
            sum_q  <= sum_d;
            prod_q <= prod_d;
            mix_q  <= mix_d;
            par_q  <= par_d;
        end
    end

    fuzz_top_stats #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .wire3_lo(wire3[ACC_W-1:0]),
        .wire0   (wire0),
        .acc     (acc),
        .cnt     (cnt),
        .max     (max)
    );

    assign y[W0_MSB:W0_LSB]     = w0_q;
    assign y[W1_MSB:W1_LSB]     = w1_q;
    assign y[W2_MSB:W2_LSB]     = w2_q;
    assign y[W3_MSB:W3_LSB]     = w3_q;
    assign y[SUM_MSB:SUM_LSB]   = sum_q;
    assign y[PROD_MSB:PROD_LSB] = prod_q;
    assign y[MIX_MSB:MIX_LSB]   = mix_q;
    assign y[PAR_MSB:PAR_LSB]   = par_q;
    assign y[ACC_MSB:ACC_LSB]   = acc;
    assign y[CNT_MSB:CNT_LSB]   = cnt;
    assign y[MAX_MSB:MAX_LSB]   = max;

endmodule

// File: tb/tb_fuzz_top_datapath.sv
// Directed vector bench for fuzz_top_datapath.
module tb_fuzz_top_datapath;

    logic         clk = 1'b0;
    logic         rst;
    logic [18:0]  wire3;
    logic [20:0]  wire2;
    logic [3:0]   wire1;
    logic [7:0]   wire0;
    logic [126:0] y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fuzz_top_datapath dut (
        .clk  (clk),
        .rst  (rst),
        .wire3(wire3),
        .wire2(wire2),
        .wire1(wire1),
        .wire0(wire0),
        .y    (y)
    );

    typedef struct {
        logic [18:0] w3;
        logic [20:0] w2;
        logic [3:0]  w1;
        logic [7:0]  w0;
        logic [8:0]  sum;
        logic [11:0] prod;
        logic [20:0] mix;
        logic        par;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [126:0] act,
                       input logic [126:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [18:0] a, input logic [20:0] b,
                         input logic [3:0] c, input logic [7:0] d);
        wire3 = a;
        wire2 = b;
        wire1 = c;
        wire0 = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{19'h0, 21'h0, 4'h7, 8'hFF,
                    9'h006, 12'hFF9, 21'h0, 1'b1};
        vecs[1] = '{19'h0, 21'h0, 4'h8, 8'h80,
                    9'h178, 12'h400, 21'h0, 1'b0};
        vecs[2] = '{19'h7FFFF, 21'h1FFFFF, 4'hF, 8'hFF,
                    9'h1FE, 12'h001, 21'h000003, 1'b0};
        vecs[3] = '{19'h0, 21'h0, 4'h0, 8'h01,
                    9'h001, 12'h000, 21'h0, 1'b1};
        vecs[4] = '{19'h00001, 21'h0F0F0F, 4'hC, 8'h10,
                    9'h00C, 12'hFC0, 21'h0F0F0B, 1'b0};
        vecs[5] = '{19'h40000, 21'h0, 4'h7, 8'h7F,
                    9'h086, 12'h379, 21'h100000, 1'b1};
        vecs[6] = '{19'h2AAAA, 21'h155555, 4'h3, 8'h9C,
                    9'h19F, 12'hED4, 21'h1FFFFD, 1'b0};

        // reset: two edges with arbitrary inputs
        rst = 1'b1;
        drive(19'($urandom), 21'($urandom), 4'($urandom), 8'($urandom));
        step();
        drive(19'($urandom), 21'($urandom), 4'($urandom), 8'($urandom));
        step();
        chk("reset_y", y, {8'h80, 119'h0});
        rst = 1'b0;

        // table vectors: one edge each
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].w3, vecs[i].w2, vecs[i].w1, vecs[i].w0);
            step();
            chk($sformatf("v%0d_w0", i), 127'(y[7:0]), 127'(vecs[i].w0));
            chk($sformatf("v%0d_w1", i), 127'(y[11:8]), 127'(vecs[i].w1));
            chk($sformatf("v%0d_w2", i), 127'(y[32:12]), 127'(vecs[i].w2));
            chk($sformatf("v%0d_w3", i), 127'(y[51:33]), 127'(vecs[i].w3));
            chk($sformatf("v%0d_sum", i), 127'(y[60:52]), 127'(vecs[i].sum));
            chk($sformatf("v%0d_prod", i), 127'(y[72:61]), 127'(vecs[i].prod));
            chk($sformatf("v%0d_mix", i), 127'(y[93:73]), 127'(vecs[i].mix));
            chk($sformatf("v%0d_par", i), 127'(y[94]), 127'(vecs[i].par));
            chk($sformatf("v%0d_cnt", i), 127'(y[118:111]), 127'(i + 1));
        end

        // accumulator wrap
        drive(19'h0FFFF, 21'h0, 4'h0, 8'h00);
        do_reset();
        step();
        chk("acc_1", 127'(y[110:95]), 127'(16'hFFFF));
        step();
        chk("acc_2", 127'(y[110:95]), 127'(16'hFFFE));
        chk("acc_cnt", 127'(y[118:111]), 127'(8'd2));

        // running maximum, then mid-stream reset
        drive(19'h0, 21'h0, 4'h0, 8'h05);
        do_reset();
        step();
        chk("max_1", 127'(y[126:119]), 127'(8'h05));
        wire0 = 8'hF0;
        step();
        chk("max_2", 127'(y[126:119]), 127'(8'h05));
        wire0 = 8'h7F;
        wire3 = 19'h00010;
        step();
        chk("max_3", 127'(y[126:119]), 127'(8'h7F));
        rst = 1'b1;
        step();
        chk("midrst_max", 127'(y[126:119]), 127'(8'h80));
        chk("midrst_acc", 127'(y[110:95]), 127'(16'h0));
        chk("midrst_y", y, {8'h80, 119'h0});
        rst = 1'b0;
        wire0 = 8'h80;
        step();
        chk("tie_max", 127'(y[126:119]), 127'(8'h80));
        chk("post_cnt", 127'(y[118:111]), 127'(8'd1));

        // counter wrap over 256 edges
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 1)
                chk("cnt_1", 127'(y[118:111]), 127'(8'd1));
            if (i == 255)
                chk("cnt_255", 127'(y[118:111]), 127'(8'd255));
            if (i == 256)
                chk("cnt_wrap", 127'(y[118:111]), 127'(8'd0));
        end

        // reset at edge 100 after release
        do_reset();
        for (int i = 1; i < 100; i++) step();
        chk("cnt_99", 127'(y[118:111]), 127'(8'd99));
        rst = 1'b1;
        step();
        chk("cnt_rst100", 127'(y[118:111]), 127'(8'd0));
        rst = 1'b0;
        step();
        chk("cnt_after", 127'(y[118:111]), 127'(8'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
